bus_terminal_fifo: RTL and testbench

Per-terminal FIFO endpoint that sits directly on one driver slot of the bus generator/arbiter (bs_gnrtr_n_rbtr). The TX side queues host packets and presents them to the bus via pndng/D_pop/pop. The RX side captures bus deliveries via push/D_push, filters them by destination ID and queues them for the host. One instance is used per driver; the block is both the bus's data source and its sink.

---
 rtl/bus_terminal_fifo.sv | 151 +++++++++++++++
 tb/tb_bus_terminal_fifo.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_terminal_fifo.sv
// Bus terminal endpoint: a TX FIFO that feeds one bus driver slot and an RX FIFO that
// takes bus deliveries filtered by destination ID. Both FIFOs are first-word-fall-through.
module bus_terminal_fifo #(
  parameter int          pckg_sz   = 16,
  parameter int          depth     = 8,
  parameter logic [7:0]  id        = 8'd0,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [pckg_sz-1:0]         wr_data,
  output logic                       tx_full,
  output logic [$clog2(depth):0]     tx_count,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  input  logic                       rd_en,
  output logic [pckg_sz-1:0]         rd_data,
  output logic                       rx_valid,
  output logic [7:0]                 tx_ovf_cnt,
  output logic [7:0]                 rx_ovf_cnt,
  output logic [7:0]                 rx_mis_cnt,
  output logic                       pop_err
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  // ---------------- TX FIFO ----------------
  logic [pckg_sz-1:0] tx_mem [depth];
  logic [AW-1:0]      tx_wr_ptr_reg;
  logic [AW-1:0]      tx_rd_ptr_reg;
  logic [CW-1:0]      tx_cnt_reg;
  logic               pop_err_reg;
  logic               tx_do_pop;
  logic               tx_do_wr;
  logic               tx_ovf_ev;

  assign pndng     = (tx_cnt_reg != '0);
  assign tx_full   = (tx_cnt_reg == FULL_CNT);
  assign tx_count  = tx_cnt_reg;
  assign D_pop     = tx_mem[tx_rd_ptr_reg];
  assign pop_err   = pop_err_reg;
  assign tx_do_pop = pop && pndng;
  // A write into a full FIFO still fits when the head leaves in the same cycle.
  assign tx_do_wr  = wr_en && (!tx_full || tx_do_pop);
  assign tx_ovf_ev = wr_en && !tx_do_wr;

  always_ff @(posedge clk) begin
    if (tx_do_wr && !reset) begin
      tx_mem[tx_wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_cnt_reg    <= '0;
      pop_err_reg   <= 1'b0;
    end else begin
      if (tx_do_wr) begin
        tx_wr_ptr_reg <= tx_wr_ptr_reg + AW'(1);
      end
      if (tx_do_pop) begin
        tx_rd_ptr_reg <= tx_rd_ptr_reg + AW'(1);
      end
      if (tx_do_wr && !tx_do_pop) begin
        tx_cnt_reg <= tx_cnt_reg + CW'(1);
      end else if (!tx_do_wr && tx_do_pop) begin
        tx_cnt_reg <= tx_cnt_reg - CW'(1);
      end
      if (pop && !pndng) begin
        pop_err_reg <= 1'b1;
      end
    end
  end

  // ---------------- RX FIFO ----------------
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [AW-1:0]      rx_wr_ptr_reg;
  logic [AW-1:0]      rx_rd_ptr_reg;
  logic [CW-1:0]      rx_cnt_reg;
  logic [7:0]         rx_dest;
  logic               rx_match;
  logic               rx_full;
  logic               rx_do_rd;
  logic               rx_do_wr;
  logic               rx_ovf_ev;
  logic               rx_mis_ev;

  assign rx_dest   = D_push[pckg_sz-1 -: 8];
  assign rx_match  = (rx_dest == id) || (rx_dest == broadcast);
  assign rx_full   = (rx_cnt_reg == FULL_CNT);
  assign rx_valid  = (rx_cnt_reg != '0);
  assign rd_data   = rx_mem[rx_rd_ptr_reg];
  assign rx_do_rd  = rd_en && rx_valid;
  assign rx_do_wr  = push && rx_match && (!rx_full || rx_do_rd);
  assign rx_ovf_ev = push && rx_match && !rx_do_wr;
  assign rx_mis_ev = push && !rx_match;

  always_ff @(posedge clk) begin
    if (rx_do_wr && !reset) begin
      rx_mem[rx_wr_ptr_reg] <= D_push;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_cnt_reg    <= '0;
    end else begin
      if (rx_do_wr) begin
        rx_wr_ptr_reg <= rx_wr_ptr_reg + AW'(1);
      end
      if (rx_do_rd) begin
        rx_rd_ptr_reg <= rx_rd_ptr_reg + AW'(1);
      end
      if (rx_do_wr && !rx_do_rd) begin
        rx_cnt_reg <= rx_cnt_reg + CW'(1);
      end else if (!rx_do_wr && rx_do_rd) begin
        rx_cnt_reg <= rx_cnt_reg - CW'(1);
      end
    end
  end

  // ---------------- saturating event counters ----------------
  logic [2:0] sat_ev;
  assign sat_ev = {rx_mis_ev, rx_ovf_ev, tx_ovf_ev};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sat
    logic [7:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (sat_ev[gi] && (cnt_reg != 8'hFF)) begin
        cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end

  assign tx_ovf_cnt = g_sat[0].cnt_reg;
  assign rx_ovf_cnt = g_sat[1].cnt_reg;
  assign rx_mis_cnt = g_sat[2].cnt_reg;

endmodule

// File: tb/tb_bus_terminal_fifo.sv
// Self-checking bench for bus_terminal_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model of both FIFOs and the counters.
module tb_bus_terminal_fifo;

  localparam int         PW    = 16;
  localparam int         DEPTH = 8;
  localparam logic [7:0] ID    = 8'h02;
  localparam logic [7:0] BC    = 8'hFF;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [PW-1:0] wr_data;
  logic          tx_full;
  logic [3:0]    tx_count;
  logic          pndng;
  logic [PW-1:0] D_pop;
  logic          pop;
  logic          push;
  logic [PW-1:0] D_push;
  logic          rd_en;
  logic [PW-1:0] rd_data;
  logic          rx_valid;
  logic [7:0]    tx_ovf_cnt;
  logic [7:0]    rx_ovf_cnt;
  logic [7:0]    rx_mis_cnt;
  logic          pop_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [PW-1:0] m_tx[$];
  logic [PW-1:0] m_rx[$];
  int            m_tx_ovf, m_rx_ovf, m_rx_mis;
  bit            m_pop_err;

  bus_terminal_fifo #(.pckg_sz(PW), .depth(DEPTH), .id(ID), .broadcast(BC)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .tx_count(tx_count), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .rd_en(rd_en), .rd_data(rd_data), .rx_valid(rx_valid),
    .tx_ovf_cnt(tx_ovf_cnt), .rx_ovf_cnt(rx_ovf_cnt), .rx_mis_cnt(rx_mis_cnt),
    .pop_err(pop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit tpop, twr, rrd, rmatch, rwr;
    if (reset) begin
      m_tx.delete();
      m_rx.delete();
      m_tx_ovf = 0; m_rx_ovf = 0; m_rx_mis = 0; m_pop_err = 0;
    end else begin
      tpop = pop && (m_tx.size() != 0);
      if (pop && m_tx.size() == 0) m_pop_err = 1;
      twr = wr_en && (m_tx.size() < DEPTH || tpop);
      if (wr_en && !twr && m_tx_ovf < 255) m_tx_ovf++;
      if (tpop) void'(m_tx.pop_front());
      if (twr) m_tx.push_back(wr_data);

      rrd    = rd_en && (m_rx.size() != 0);
      rmatch = (D_push[PW-1:PW-8] == ID) || (D_push[PW-1:PW-8] == BC);
      if (push && !rmatch && m_rx_mis < 255) m_rx_mis++;
      rwr = push && rmatch && (m_rx.size() < DEPTH || rrd);
      if (push && rmatch && !rwr && m_rx_ovf < 255) m_rx_ovf++;
      if (rrd) void'(m_rx.pop_front());
      if (rwr) m_rx.push_back(D_push);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; pop = 0; push = 0; rd_en = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle(); wr_data = '0; D_push = '0;
    cycle();
    cycle();
    reset = 0;
    n_cmp++; if (pndng !== 1'b0) begin n_fail++; $display("FAIL rst_pndng: got %0h, expected 0", pndng); end
    n_cmp++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL rst_tx_full: got %0h, expected 0", tx_full); end
    n_cmp++; if (tx_count !== 4'd0) begin n_fail++; $display("FAIL rst_tx_count: got %0h, expected 0", tx_count); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got %0h, expected 0", rx_valid); end
    n_cmp++; if (tx_ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_tx_ovf: got %0h, expected 0", tx_ovf_cnt); end
    n_cmp++; if (rx_ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_rx_ovf: got %0h, expected 0", rx_ovf_cnt); end
    n_cmp++; if (rx_mis_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_rx_mis: got %0h, expected 0", rx_mis_cnt); end
    n_cmp++; if (pop_err !== 1'b0) begin n_fail++; $display("FAIL rst_pop_err: got %0h, expected 0", pop_err); end
    $display("test_reset done");
  endtask

  task automatic test_tx_basic();
    logic [PW-1:0] pkt [3];
    pkt[0] = 16'h0101; pkt[1] = 16'h0202; pkt[2] = 16'h0303;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1; wr_data = pkt[i];
      cycle();
      if (i == 0) begin
        n_cmp++; if (pndng !== 1'b1 || D_pop !== 16'h0101) begin
          n_fail++; $display("FAIL tx_first_latency: got pndng=%0h D_pop=%0h, expected 1/0101", pndng, D_pop);
        end
      end
    end
    idle();
    n_cmp++; if (tx_count !== 4'd3) begin n_fail++; $display("FAIL tx_basic_count: got %0h, expected 3", tx_count); end
    n_cmp++; if (D_pop !== 16'h0101) begin n_fail++; $display("FAIL tx_basic_head: got %0h, expected 0101", D_pop); end
    for (int i = 1; i <= 3; i++) begin
      pop = 1;
      cycle();
      pop = 0;
      if (i < 3) begin
        n_cmp++; if (pndng !== 1'b1 || D_pop !== pkt[i]) begin
          n_fail++; $display("FAIL tx_pop_%0d: got pndng=%0h D_pop=%0h, expected 1/%0h", i, pndng, D_pop, pkt[i]);
        end
      end
    end
    n_cmp++; if (pndng !== 1'b0) begin n_fail++; $display("FAIL tx_drained: got %0h, expected 0", pndng); end
    n_cmp++; if (pop_err !== 1'b0) begin n_fail++; $display("FAIL tx_basic_pop_err: got %0h, expected 0", pop_err); end
    $display("test_tx_basic done");
  endtask

  task automatic test_tx_full();
    logic [PW-1:0] d [10];
    for (int i = 0; i < 10; i++) d[i] = PW'($urandom);
    for (int i = 0; i < 9; i++) begin
      wr_en = 1; wr_data = d[i];
      cycle();
    end
    idle();
    n_cmp++; if (tx_full !== 1'b1) begin n_fail++; $display("FAIL tx_full_flag: got %0h, expected 1", tx_full); end
    n_cmp++; if (tx_count !== 4'd8) begin n_fail++; $display("FAIL tx_full_count: got %0h, expected 8", tx_count); end
    n_cmp++; if (tx_ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL tx_full_ovf: got %0h, expected 1", tx_ovf_cnt); end
    wr_en = 1; wr_data = d[9]; pop = 1;
    cycle();
    idle();
    n_cmp++; if (tx_count !== 4'd8) begin n_fail++; $display("FAIL tx_wr_pop_count: got %0h, expected 8", tx_count); end
    n_cmp++; if (tx_ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL tx_wr_pop_ovf: got %0h, expected 1", tx_ovf_cnt); end
    n_cmp++; if (D_pop !== d[1]) begin n_fail++; $display("FAIL tx_wr_pop_head: got %0h, expected %0h", D_pop, d[1]); end
    for (int i = 0; i < 8; i++) begin
      pop = 1;
      cycle();
      if (i == 0) begin
        n_cmp++; if (tx_full !== 1'b0) begin n_fail++; $display("FAIL tx_unfull: got %0h, expected 0", tx_full); end
      end
    end
    idle();
    n_cmp++; if (pndng !== 1'b0 || tx_count !== 4'd0) begin
      n_fail++; $display("FAIL tx_full_drain: got pndng=%0h count=%0h, expected 0/0", pndng, tx_count);
    end
    $display("test_tx_full done");
  endtask

  task automatic test_rx_filter();
    logic [PW-1:0] pk [3];
    pk[0] = 16'h02AA; pk[1] = 16'hFF55; pk[2] = 16'h0377;
    for (int i = 0; i < 3; i++) begin
      push = 1; D_push = pk[i];
      cycle();
    end
    idle();
    n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx_filt_valid: got %0h, expected 1", rx_valid); end
    n_cmp++; if (rx_mis_cnt !== 8'd1) begin n_fail++; $display("FAIL rx_filt_mis: got %0h, expected 1", rx_mis_cnt); end
    n_cmp++; if (rd_data !== 16'h02AA) begin n_fail++; $display("FAIL rx_filt_head0: got %0h, expected 02AA", rd_data); end
    rd_en = 1; cycle(); idle();
    n_cmp++; if (rd_data !== 16'hFF55) begin n_fail++; $display("FAIL rx_filt_head1: got %0h, expected FF55", rd_data); end
    rd_en = 1; cycle(); idle();
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_filt_empty: got %0h, expected 0", rx_valid); end
    rd_en = 1; cycle(); idle();
    n_cmp++; if (rx_valid !== 1'b0 || rx_ovf_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rx_rd_empty: got valid=%0h ovf=%0h, expected 0/0", rx_valid, rx_ovf_cnt);
    end
    $display("test_rx_filter done");
  endtask

  task automatic test_rx_full();
    logic [PW-1:0] exp_d;
    for (int i = 0; i < 8; i++) begin
      push = 1; D_push = 16'h0210 + PW'(i);
      cycle();
    end
    push = 1; D_push = 16'h0201; rd_en = 1;
    cycle();
    idle();
    n_cmp++; if (rx_ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL rx_full_rdpush_ovf: got %0h, expected 0", rx_ovf_cnt); end
    n_cmp++; if (rd_data !== 16'h0211) begin n_fail++; $display("FAIL rx_full_rdpush_head: got %0h, expected 0211", rd_data); end
    push = 1; D_push = 16'h0202;
    cycle();
    idle();
    n_cmp++; if (rx_ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL rx_full_ovf: got %0h, expected 1", rx_ovf_cnt); end
    for (int i = 0; i < 8; i++) begin
      exp_d = (i < 7) ? 16'h0211 + PW'(i) : 16'h0201;
      n_cmp++; if (rx_valid !== 1'b1 || rd_data !== exp_d) begin
        n_fail++; $display("FAIL rx_drain_%0d: got valid=%0h data=%0h, expected 1/%0h", i, rx_valid, rd_data, exp_d);
      end
      rd_en = 1; cycle(); idle();
    end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_full_drained: got %0h, expected 0", rx_valid); end
    $display("test_rx_full done");
  endtask

  task automatic test_pop_err();
    pop = 1; cycle(); idle();
    n_cmp++; if (pop_err !== 1'b1) begin n_fail++; $display("FAIL pop_err_set: got %0h, expected 1", pop_err); end
    wr_en = 1; wr_data = 16'h1234; cycle(); idle();
    pop = 1; cycle(); idle();
    n_cmp++; if (pop_err !== 1'b1 || pndng !== 1'b0) begin
      n_fail++; $display("FAIL pop_err_sticky: got err=%0h pndng=%0h, expected 1/0", pop_err, pndng);
    end
    $display("test_pop_err done");
  endtask

  task automatic test_random();
    logic [7:0] dst;
    for (int c = 0; c < 400; c++) begin
      wr_en   = ($urandom_range(0, 9) < ((c < 200) ? 7 : 3));
      pop     = ($urandom_range(0, 9) < ((c < 200) ? 3 : 7));
      push    = ($urandom_range(0, 9) < ((c < 200) ? 7 : 3));
      rd_en   = ($urandom_range(0, 9) < ((c < 200) ? 3 : 7));
      wr_data = PW'($urandom);
      case ($urandom_range(0, 3))
        0, 3:    dst = ID;
        1:       dst = BC;
        default: dst = 8'h05;
      endcase
      D_push = {dst, 8'($urandom)};
      cycle();
      n_cmp++; if (tx_count !== 4'(m_tx.size())) begin n_fail++; $display("FAIL rnd_tx_count c%0d: got %0h, expected %0h", c, tx_count, m_tx.size()); end
      n_cmp++; if (pndng !== (m_tx.size() != 0)) begin n_fail++; $display("FAIL rnd_pndng c%0d: got %0h, expected %0h", c, pndng, m_tx.size() != 0); end
      n_cmp++; if (tx_full !== (m_tx.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_tx_full c%0d: got %0h, expected %0h", c, tx_full, m_tx.size() == DEPTH); end
      n_cmp++; if (rx_valid !== (m_rx.size() != 0)) begin n_fail++; $display("FAIL rnd_rx_valid c%0d: got %0h, expected %0h", c, rx_valid, m_rx.size() != 0); end
      if (m_tx.size() != 0) begin
        n_cmp++; if (D_pop !== m_tx[0]) begin n_fail++; $display("FAIL rnd_D_pop c%0d: got %0h, expected %0h", c, D_pop, m_tx[0]); end
      end
      if (m_rx.size() != 0) begin
        n_cmp++; if (rd_data !== m_rx[0]) begin n_fail++; $display("FAIL rnd_rd_data c%0d: got %0h, expected %0h", c, rd_data, m_rx[0]); end
      end
      n_cmp++; if (tx_ovf_cnt !== 8'(m_tx_ovf)) begin n_fail++; $display("FAIL rnd_tx_ovf c%0d: got %0h, expected %0h", c, tx_ovf_cnt, m_tx_ovf); end
      n_cmp++; if (rx_ovf_cnt !== 8'(m_rx_ovf)) begin n_fail++; $display("FAIL rnd_rx_ovf c%0d: got %0h, expected %0h", c, rx_ovf_cnt, m_rx_ovf); end
      n_cmp++; if (rx_mis_cnt !== 8'(m_rx_mis)) begin n_fail++; $display("FAIL rnd_rx_mis c%0d: got %0h, expected %0h", c, rx_mis_cnt, m_rx_mis); end
      n_cmp++; if (pop_err !== m_pop_err) begin n_fail++; $display("FAIL rnd_pop_err c%0d: got %0h, expected %0h", c, pop_err, m_pop_err); end
    end
    idle();
    $display("test_random done: tx_q=%0d rx_q=%0d", m_tx.size(), m_rx.size());
  endtask

  task automatic test_reset_mid();
    // Fill known occupancy from an empty state.
    reset = 1; cycle(); reset = 0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_data = 16'hA000 + PW'(i);
      push = (i < 4); D_push = {ID, 8'(i)};
      cycle();
    end
    idle();
    n_cmp++; if (tx_count !== 4'd5 || rx_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_prefill: got count=%0h valid=%0h, expected 5/1", tx_count, rx_valid);
    end
    reset = 1; wr_en = 1; push = 1; pop = 1; wr_data = 16'hBEEF; D_push = {ID, 8'h33};
    cycle();
    reset = 0; idle();
    n_cmp++; if (pndng !== 1'b0 || rx_valid !== 1'b0 || tx_count !== 4'd0) begin
      n_fail++; $display("FAIL mid_reset: got pndng=%0h valid=%0h count=%0h, expected 0/0/0", pndng, rx_valid, tx_count);
    end
    n_cmp++; if (tx_ovf_cnt !== 8'd0 || rx_ovf_cnt !== 8'd0 || rx_mis_cnt !== 8'd0 || pop_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_cnts: got %0h/%0h/%0h/%0h, expected 0/0/0/0", tx_ovf_cnt, rx_ovf_cnt, rx_mis_cnt, pop_err);
    end
    for (int i = 0; i < 308; i++) begin
      wr_en = 1; wr_data = PW'($urandom);
      cycle();
    end
    idle();
    n_cmp++; if (tx_ovf_cnt !== 8'd255) begin n_fail++; $display("FAIL tx_ovf_sat: got %0h, expected ff", tx_ovf_cnt); end
    n_cmp++; if (tx_count !== 4'd8) begin n_fail++; $display("FAIL tx_sat_count: got %0h, expected 8", tx_count); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_rx_filter();
    test_rx_full();
    test_pop_err();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
